io_input_buffer: RTL and testbench
==================================

// Module: io_input_buffer
// PURPOSE
//  Input stage for the board switches and push-buttons, feeding the load-data mux.
//  - Each input runs through a 2-flop synchroniser and then a debounce filter.
//  - Produces b_io_sw (read at 0x1001_0) and b_io_btn (read at 0x1001_1).
//  - Buttons also get sticky "pressed" flags that the LSU clears with an ack pulse.
// PARAMETERS
//  SW_W        18       number of slide switches (1..32)
//  BTN_W       4        number of push-buttons (1..16); pins are active-low
//  DEB_CYCLES  500000   consecutive stable cycles needed to accept a new level (>=1)
// PORTS
//  i_clk        in   1      system clock
//  i_reset      in   1      asynchronous, active-low reset
//  i_io_sw      in   SW_W   raw switch pins, asynchronous to i_clk
//  i_io_btn     in   BTN_W  raw button pins, asynchronous, 0 = pressed
//  i_btn_ack    in   1      1-cycle pulse from LSU: clear sticky flags selected by i_ack_mask
//  i_ack_mask   in   BTN_W  which sticky flags to clear when i_btn_ack=1
//  b_io_sw      out  32     {zeros, debounced switch levels}
//  b_io_btn     out  32     [BTN_W-1:0] debounced pressed level (1 = pressed);
//                           [16+:BTN_W] sticky press flags; all other bits 0
//  o_btn_event  out  1      1-cycle pulse when any debounced press edge occurs
// BEHAVIOUR
//  Reset (i_reset=0, asynchronous):
//   - Synchroniser flops <= 1 for buttons, 0 for switches.
//   - Stable levels: switches = 0, buttons = released.
//   - All counters = 0; sticky flags = 0.
//   - Outputs: b_io_sw = 0, b_io_btn = 0, o_btn_event = 0.
//   - Reset deassertion is used as-is; no internal reset synchroniser.
//  Synchroniser: two flops per bit; every bit is independent.
//  Debounce, per bit, with its own counter of width $clog2(DEB_CYCLES+1):
//   - If sync == stable: counter <= 0.
//   - Else if counter == DEB_CYCLES-1: stable <= sync, counter <= 0.
//   - Else: counter <= counter + 1. The counter saturates and never wraps.
//   - A glitch shorter than DEB_CYCLES cycles resets the count and never reaches the output.
//  Latency:
//   - A pin change held steady is visible on b_io_* exactly 2 + DEB_CYCLES cycles after
//     the first clock edge that samples it.
//   - The outputs are registered: they come straight from the stable flops, with no
//     combinational path from the pins.
//  Button polarity: level bit = ~stable_btn, so 1 = pressed.
//  Press edge: on the cycle a button's stable level goes released->pressed:
//   - Its sticky flag is set.
//   - o_btn_event = 1 for that one cycle (OR across all buttons).
//  A release edge sets nothing.
//  Sticky clear:
//   - When i_btn_ack=1: flag[k] <= 0 for every k with i_ack_mask[k]=1.
//   - Flags outside the mask keep their value.
//  Set and clear on the same flag in the same cycle: set wins, so no press is lost.
//  i_btn_ack with an all-zero mask has no effect.
//  Reset mid-debounce: the counter is cleared and the stable level returns to its
//  reset value; no event is produced.
//  Switches produce no sticky flags and no events.
// TESTING (bench uses DEB_CYCLES=4, SW_W=18, BTN_W=4)
//  1 Reset: hold i_reset=0 with random pins.
//    -> b_io_sw=0, b_io_btn=0, o_btn_event=0.
//  2 Switch settle: set i_io_sw=18'h2A5A5 and hold.
//    -> b_io_sw=32'h0002A5A5 exactly 6 cycles later; still 0 at cycle 5.
//  3 Glitch reject: pulse btn[0] low for 3 cycles, then high.
//    -> b_io_btn stays 0; o_btn_event never asserts.
//  4 Press and stick: hold btn[2] low for 10 cycles, then release.
//    -> At cycle 6: bit 2 = 1, bit 18 = 1, and one o_btn_event pulse.
//    -> After release + 6 cycles: bit 2 = 0 and bit 18 is still 1.
//  5 Ack vs set: on the cycle btn[1]'s press edge lands, drive i_btn_ack=1 with
//    mask=4'b0110.
//    -> Bit 17 = 1 (set wins); bit 18 is cleared.
//  6 Async reset mid-count: assert i_reset 2 cycles into a btn[3] press.
//    -> All outputs are 0 immediately, without waiting for a clock edge.
//    -> After release of reset with btn[3] held low: the press is seen after another
//       6 cycles.

Source files
------------

// File: rtl/io_input_buffer_if.sv
// LSU-facing side of the board input buffer: sticky-flag acknowledge and the
// two read words that feed the load-data mux.
interface io_input_buffer_if #(
    parameter int BTN_W = 4
);
    logic             i_btn_ack;
    logic [BTN_W-1:0] i_ack_mask;
    logic [31:0]      b_io_sw;
    logic [31:0]      b_io_btn;
    logic             o_btn_event;

    modport master (
        output i_btn_ack, i_ack_mask,
        input  b_io_sw, b_io_btn, o_btn_event
    );

    modport slave (
        input  i_btn_ack, i_ack_mask,
        output b_io_sw, b_io_btn, o_btn_event
    );
endinterface

// File: rtl/io_input_buffer.sv
// Board switch/button input stage: per-bit 2-flop synchroniser and debounce,
// plus sticky button-press flags cleared by an LSU acknowledge.
module io_input_buffer #(
    parameter int SW_W       = 18,
    parameter int BTN_W      = 4,
    parameter int DEB_CYCLES = 500000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [SW_W-1:0]   i_io_sw,
    input  logic [BTN_W-1:0]  i_io_btn,
    io_input_buffer_if.slave  lsu
);
    localparam int N     = SW_W + BTN_W;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    // Buttons idle high (released), switches idle low.
    localparam logic [N-1:0] RST_VAL = {{BTN_W{1'b1}}, {SW_W{1'b0}}};

    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [N-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [BTN_W-1:0] sticky_q, sticky_d;
    logic             event_q, event_d;

    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] clear;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sync1_d  = {i_io_btn, i_io_sw};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        // Press edge: stable button level moving from released (1) to pressed (0).
        press    = stable_q[N-1:SW_W] & ~stable_d[N-1:SW_W];
        clear    = lsu.i_btn_ack ? lsu.i_ack_mask : '0;
        sticky_d = (sticky_q & ~clear) | press;
        event_d  = |press;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            sticky_q <= '0;
            event_q  <= 1'b0;
            // NOTE: the counter array is a bank of flops, not RAM, so it is reset like any other state.
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            sticky_q <= sticky_d;
            event_q  <= event_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        lsu.b_io_sw                = 32'(stable_q[SW_W-1:0]);
        lsu.b_io_btn               = '0;
        lsu.b_io_btn[BTN_W-1:0]    = ~stable_q[N-1:SW_W];
        lsu.b_io_btn[16 +: BTN_W]  = sticky_q;
        lsu.o_btn_event            = event_q;
    end
endmodule

// File: tb/tb_io_input_buffer.sv
// Directed bench for io_input_buffer with DEB_CYCLES=4: latency, glitch
// rejection, sticky flags, ack/set collision and asynchronous reset.
module tb_io_input_buffer;
    localparam int SW_W  = 18;
    localparam int BTN_W = 4;

    logic             clk;
    logic             rst_n;
    logic [SW_W-1:0]  io_sw;
    logic [BTN_W-1:0] io_btn;

    int n_checks;
    int n_errors;

    io_input_buffer_if #(.BTN_W(BTN_W)) lsu ();

    io_input_buffer #(
        .SW_W       (SW_W),
        .BTN_W      (BTN_W),
        .DEB_CYCLES (4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_io_sw  (io_sw),
        .i_io_btn (io_btn),
        .lsu      (lsu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        io_sw          = '0;
        io_btn         = '1;
        lsu.i_btn_ack  = 1'b0;
        lsu.i_ack_mask = '0;

        // 1: reset holds outputs at zero whatever the pins do
        for (int i = 0; i < 3; i++) begin
            io_sw  = SW_W'($urandom);
            io_btn = BTN_W'($urandom);
            tick();
            check("rst_sw",  lsu.b_io_sw,  32'h0);
            check("rst_btn", lsu.b_io_btn, 32'h0);
            check("rst_evt", 32'(lsu.o_btn_event), 32'h0);
        end
        io_sw  = '0;
        io_btn = '1;
        tick(3);
        rst_n = 1'b1;
        tick(8);
        check("idle_btn", lsu.b_io_btn, 32'h0);

        // 2: switch settle latency
        io_sw = 18'h2A5A5;
        tick(5);
        check("sw_cyc5", lsu.b_io_sw, 32'h0);
        tick();
        check("sw_cyc6", lsu.b_io_sw, 32'h0002_A5A5);

        // 3: 3-cycle glitch on btn[0] is rejected
        io_btn = 4'b1110;
        tick(3);
        io_btn = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            check("glitch_btn", lsu.b_io_btn, 32'h0);
            check("glitch_evt", 32'(lsu.o_btn_event), 32'h0);
            tick();
        end

        // 4: press btn[2] for 10 cycles, then release
        io_btn = 4'b1011;
        tick(5);
        check("p2_cyc5", lsu.b_io_btn, 32'h0);
        check("p2_evt5", 32'(lsu.o_btn_event), 32'h0);
        tick();
        check("p2_cyc6", lsu.b_io_btn, 32'h0004_0004);
        check("p2_evt6", 32'(lsu.o_btn_event), 32'h1);
        tick();
        check("p2_evt7", 32'(lsu.o_btn_event), 32'h0);
        tick(3);
        io_btn = 4'b1111;
        tick(5);
        check("r2_cyc5", lsu.b_io_btn, 32'h0004_0004);
        tick();
        check("r2_cyc6", lsu.b_io_btn, 32'h0004_0000);
        check("r2_evt",  32'(lsu.o_btn_event), 32'h0);

        // 5: ack lands with btn[1] press edge; set wins on 17, 18 is cleared
        io_btn = 4'b1101;
        tick(5);
        check("p1_cyc5", lsu.b_io_btn, 32'h0004_0000);
        lsu.i_btn_ack  = 1'b1;
        lsu.i_ack_mask = 4'b0110;
        tick();
        lsu.i_btn_ack  = 1'b0;
        lsu.i_ack_mask = 4'b0000;
        check("ack_set", lsu.b_io_btn, 32'h0002_0002);
        check("ack_evt", 32'(lsu.o_btn_event), 32'h1);
        io_btn = 4'b1111;
        tick(8);
        check("r1_settle", lsu.b_io_btn, 32'h0002_0000);

        // 6: asynchronous reset two cycles into a btn[3] press
        io_btn = 4'b0111;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sw",  lsu.b_io_sw,  32'h0);
        check("arst_btn", lsu.b_io_btn, 32'h0);
        check("arst_evt", 32'(lsu.o_btn_event), 32'h0);
        tick();
        rst_n = 1'b1;
        tick(5);
        check("p3_cyc5", lsu.b_io_btn, 32'h0);
        check("sw_post5", lsu.b_io_sw, 32'h0);
        tick();
        check("p3_cyc6", lsu.b_io_btn, 32'h0008_0008);
        check("p3_evt",  32'(lsu.o_btn_event), 32'h1);
        check("sw_post6", lsu.b_io_sw, 32'h0002_A5A5);

        // ack with an empty mask does nothing; a matching mask clears bit 19
        lsu.i_btn_ack  = 1'b1;
        lsu.i_ack_mask = 4'b0000;
        tick();
        check("ack_nomask", lsu.b_io_btn, 32'h0008_0008);
        lsu.i_ack_mask = 4'b1000;
        tick();
        lsu.i_btn_ack  = 1'b0;
        lsu.i_ack_mask = 4'b0000;
        check("ack_clr3", lsu.b_io_btn, 32'h0000_0008);
        tick(2);
        check("ack_hold", lsu.b_io_btn, 32'h0000_0008);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
